piece_move_checker: RTL



---
 rtl/piece_move_checker_if.sv | 31 +++
 rtl/piece_move_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_move_checker_if.sv
// Move-request / board-RAM / result bundle for piece_move_checker.
// master: requester plus board RAM side; slave: the checker itself.
interface piece_move_checker_if #(
  parameter int X_W   = 4,
  parameter int Y_W   = 4,
  parameter int IDX_W = 7
);
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_piece;
  logic [X_W-1:0]     req_x;
  logic [Y_W-1:0]     req_y;
  logic [1:0]         req_rot;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_addr;
  logic               rd_data;
  logic               res_valid;
  logic               res_legal;
  logic [X_W-1:0]     res_x;
  logic [4*IDX_W-1:0] res_blks;

  modport master (
    output req_valid, req_piece, req_x, req_y, req_rot, rd_data,
    input  req_ready, rd_en, rd_addr, res_valid, res_legal, res_x, res_blks
  );

  modport slave (
    input  req_valid, req_piece, req_x, req_y, req_rot, rd_data,
    output req_ready, rd_en, rd_addr, res_valid, res_legal, res_x, res_blks
  );
endinterface

// File: rtl/piece_move_checker.sv
// Expands a move request (piece, x, y, rot) to four board cell indices,
// checks the board edges, reads the cells from the board RAM and reports
// legal/illegal together with the indices.
// Optional feature macro: PIECE_KICK_EN (x-1 / x+1 wall-kick retries).
module piece_move_checker #(
  parameter int BOARD_W = 7,
  parameter int BOARD_H = 10,
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int IDX_W   = 7
) (
  input logic                clk,
  input logic                rst,
  piece_move_checker_if.slave bus
);
  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam int IW = IDX_W + 1;
  localparam logic [CW-1:0] BW_C = CW'(BOARD_W);
  localparam logic [CW-1:0] BH_C = CW'(BOARD_H);
  localparam logic [IW-1:0] BW_I = IW'(BOARD_W);

  typedef enum logic [1:0] {IDLE, CALC, READ, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]         lat_piece;
  logic [X_W-1:0]     lat_x;
  logic [Y_W-1:0]     lat_y;
  logic [1:0]         lat_rot;
  logic [X_W-1:0]     cur_x;
  logic [IDX_W-1:0]   blks [4];
  logic [2:0]         rd_idx;
  logic               rd_pending;
  logic               res_legal_q;
  logic [X_W-1:0]     res_x_q;
  logic [4*IDX_W-1:0] res_blks_q;

  logic [15:0]        ofs;
  logic [2:0]         w, h;
  logic [CW-1:0]      x_sum, y_sum;
  logic               empty, x_fail, y_fail, in_bounds;
  logic [IDX_W-1:0]   calc_blks [4];
  logic [4*IDX_W-1:0] calc_flat, blks_flat;
  logic               accept, hit, reads_done, retry;

  // Shape table: offsets packed {dx1,dy1,dx2,dy2,dx3,dy3,dx4,dy4} plus bounding box
  always_comb begin
    ofs = '0;
    w   = 3'd0;
    h   = 3'd0;
    if (lat_piece > 3'd2) begin
      w = lat_rot[0] ? 3'd2 : 3'd3;
      h = lat_rot[0] ? 3'd3 : 3'd2;
    end
    case (lat_piece)
      3'd1: begin
        if (lat_rot[0]) begin
          ofs = 16'b00_00_00_01_00_10_00_11;
          w   = 3'd1;
          h   = 3'd4;
        end else begin
          ofs = 16'b00_00_01_00_10_00_11_00;
          w   = 3'd4;
          h   = 3'd1;
        end
      end
      3'd2: begin
        ofs = 16'b00_00_01_00_00_01_01_01;
        w   = 3'd2;
        h   = 3'd2;
      end
      3'd3: begin
        case (lat_rot)
          2'd0:    ofs = 16'b01_00_00_01_01_01_10_01;
          2'd1:    ofs = 16'b00_00_00_01_00_10_01_01;
          2'd2:    ofs = 16'b00_00_01_00_10_00_01_01;
          default: ofs = 16'b01_00_01_01_01_10_00_01;
        endcase
      end
      3'd4: ofs = lat_rot[0] ? 16'b00_00_00_01_01_01_01_10 : 16'b01_00_10_00_00_01_01_01;
      3'd5: ofs = lat_rot[0] ? 16'b01_00_00_01_00_10_01_01 : 16'b00_00_01_00_01_01_10_01;
      3'd6: begin
        case (lat_rot)
          2'd0:    ofs = 16'b00_00_00_01_01_01_10_01;
          2'd1:    ofs = 16'b00_00_00_01_00_10_01_00;
          2'd2:    ofs = 16'b00_00_01_00_10_00_10_01;
          default: ofs = 16'b01_00_01_01_01_10_00_10;
        endcase
      end
      3'd7: begin
        case (lat_rot)
          2'd0:    ofs = 16'b00_01_00_00_01_00_10_00;
          2'd1:    ofs = 16'b01_00_01_01_01_10_00_00;
          2'd2:    ofs = 16'b00_01_01_01_10_01_10_00;
          default: ofs = 16'b00_00_00_01_00_10_01_10;
        endcase
      end
      default: ofs = '0;
    endcase
  end

  // Edge check in widened arithmetic and cell index expansion for the current attempt
  always_comb begin
    logic [15:0]   sh;
    logic [IW-1:0] idx;
    x_sum     = CW'(cur_x) + CW'(w);
    y_sum     = CW'(lat_y) + CW'(h);
    empty     = (lat_piece == 3'd0);
    x_fail    = (x_sum > BW_C);
    y_fail    = (y_sum > BH_C);
    in_bounds = !empty && !x_fail && !y_fail;
    sh        = ofs;
    idx       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = (IW'(lat_y) + IW'(sh[13:12])) * BW_I + IW'(cur_x) + IW'(sh[15:14]);
      calc_blks[k] = idx[IDX_W-1:0];
      sh = sh << 4;
    end
    calc_flat = {calc_blks[3], calc_blks[2], calc_blks[1], calc_blks[0]};
    blks_flat = {blks[3], blks[2], blks[1], blks[0]};
  end

  // Handshake and read-phase status
  always_comb begin
    accept     = (state == IDLE) && bus.req_valid;
    hit        = (state == READ) && rd_pending && bus.rd_data;
    reads_done = (rd_idx == 3'd4);
  end

`ifdef PIECE_KICK_EN
  logic [1:0]    attempt;
  logic [CW-1:0] x_plus;
  logic          can_minus, can_plus;
  logic [1:0]    next_att;
  logic [X_W-1:0] next_x;

  // Kick sequencing: attempt 0 = req_x, 1 = req_x-1, 2 = req_x+1.
  // Only an x-edge failure of the first attempt starts the chain; once kicked,
  // any failure (edge or occupied cell) moves on to the next candidate.
  always_comb begin
    x_plus    = CW'(lat_x) + CW'(1);
    can_minus = (attempt == 2'd0) && (lat_x != '0);
    can_plus  = (attempt != 2'd2) && (x_plus < BW_C);
    next_att  = can_minus ? 2'd1 : 2'd2;
    next_x    = can_minus ? (lat_x - X_W'(1)) : x_plus[X_W-1:0];
    retry     = 1'b0;
    if (state == CALC && !in_bounds)
      retry = (can_minus || can_plus) &&
              ((attempt != 2'd0) || (x_fail && !y_fail && !empty));
    else if (hit)
      retry = (can_minus || can_plus) && (attempt != 2'd0);
  end

  // Attempt register and x of the attempt under test
  always_ff @(posedge clk) begin
    if (rst) begin
      attempt <= 2'd0;
      cur_x   <= '0;
    end else if (accept) begin
      attempt <= 2'd0;
      cur_x   <= bus.req_x;
    end else if (retry) begin
      attempt <= next_att;
      cur_x   <= next_x;
    end
  end
`else
  // Single attempt: the checked x is always the requested x
  always_comb begin
    cur_x = lat_x;
    retry = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req_valid) state_nx = CALC;
      CALC: begin
        if (retry)          state_nx = CALC;
        else if (in_bounds) state_nx = READ;
        else                state_nx = DONE;
      end
      READ: begin
        if (retry)                   state_nx = CALC;
        else if (hit || reads_done)  state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs; a hit suppresses the read strobe in the same cycle the data returns
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.res_valid = (state == DONE);
    bus.rd_en     = (state == READ) && !reads_done && !hit;
    bus.rd_addr   = bus.rd_en ? blks[rd_idx[1:0]] : '0;
    bus.res_legal = res_legal_q;
    bus.res_x     = res_x_q;
    bus.res_blks  = res_blks_q;
  end

  // Request latch, read sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_piece  <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_rot    <= '0;
      blks       <= '{default: '0};
      rd_idx     <= '0;
      rd_pending <= 1'b0;
      res_legal_q <= 1'b0;
      res_x_q    <= '0;
      res_blks_q <= '1;
    end else begin
      rd_pending <= bus.rd_en;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_piece <= bus.req_piece;
            lat_x     <= bus.req_x;
            lat_y     <= bus.req_y;
            lat_rot   <= bus.req_rot;
          end
        end
        CALC: begin
          blks   <= calc_blks;
          rd_idx <= '0;
          if (!retry && !in_bounds) begin
            res_legal_q <= 1'b0;
            res_x_q     <= lat_x;
            res_blks_q  <= '1;
          end
        end
        READ: begin
          if (bus.rd_en) rd_idx <= rd_idx + 3'd1;
          if (!retry) begin
            if (hit) begin
              res_legal_q <= 1'b0;
              res_x_q     <= lat_x;
              res_blks_q  <= blks_flat;
            end else if (reads_done) begin
              res_legal_q <= 1'b1;
              res_x_q     <= cur_x;
              res_blks_q  <= blks_flat;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // calc_flat is the same data as calc_blks, kept for readability of the packing
  logic unused_flat;
  always_comb unused_flat = ^calc_flat;
endmodule
